flp_pipe_arbiter: RTL and testbench

- Shares one pipelined floating-point unit (FLP adder or FLP multiplier, fixed LAT-cycle latency, one operation accepted per cycle) between two requesters.
- Arbitrates requests round-robin and registers the granted operands onto the unit inputs.
- Tracks the owner of every in-flight operation in a tag delay line and steers each result back to the requester that issued it.
- Sits between the requester front-ends and the FLP_adder/FLP_mul pipeline instance.

---
 rtl/flp_pipe_arbiter_pkg.sv | 15 +
 rtl/flp_tag_delay.sv | 41 ++++
 rtl/flp_pipe_arbiter.sv | 107 ++++++++++
 tb/tb_flp_pipe_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/flp_pipe_arbiter_pkg.sv
// Shared types and constants for the two-requester FLP unit arbiter.
package flp_pipe_arbiter_pkg;

    localparam int W_DEF = 32;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    // One entry of the in-flight ownership line
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/flp_tag_delay.sv
// Fixed-length ownership line: one tag per issued slot, shifted every cycle
// with no stall so it stays aligned with the FLP unit pipeline.
module flp_tag_delay
    import flp_pipe_arbiter_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  tag_t tag_i,
    output logic vld_o,
    output logic id_o,
    output logic any_vld_o
);

    tag_t [LAT-1:0] stage_q;

    // Shift line; reset drops every in-flight tag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Any valid stage means an operation is still in the unit
    always_comb begin
        any_vld_o = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            any_vld_o = any_vld_o | stage_q[i].valid;
        end
    end

    assign vld_o = stage_q[LAT-1].valid;
    assign id_o  = stage_q[LAT-1].id;

endmodule

// File: rtl/flp_pipe_arbiter.sv
// Shares one fixed-latency pipelined FLP unit between two requesters:
// round-robin grant, registered operands to the unit, and result steering
// back to the issuing requester via a tag line matched to the unit latency.
module flp_pipe_arbiter
    import flp_pipe_arbiter_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         res0_valid,
    output logic [W-1:0] res0_d,
    output logic         res1_valid,
    output logic [W-1:0] res1_d,
    output logic [W-1:0] unit_a,
    output logic [W-1:0] unit_b,
    input  logic [W-1:0] unit_d,
    output logic         busy
);

    logic         last_q, last_d;
    logic         gnt0, gnt1, xfer, gnt_id;
    logic [W-1:0] unit_a_q, unit_a_d, unit_b_q, unit_b_d;
    logic         res0_vld_q, res0_vld_d, res1_vld_q, res1_vld_d;
    logic [W-1:0] res0_dat_q, res0_dat_d, res1_dat_q, res1_dat_d;
    tag_t         tag_in;
    logic         ret_vld, ret_id, any_vld;

    // Grant: a lone requester wins; under contention the one not served last wins
    always_comb begin
        gnt0     = req0_valid && (!req1_valid || (last_q == ID_REQ1));
        gnt1     = req1_valid && !gnt0;
        xfer     = gnt0 || gnt1;
        gnt_id   = gnt1 ? ID_REQ1 : ID_REQ0;
        last_d   = xfer ? gnt_id : last_q;
        tag_in   = '{valid: xfer, id: gnt_id};
        unit_a_d = unit_a_q;
        unit_b_d = unit_b_q;
        if (gnt0) begin
            unit_a_d = req0_a;
            unit_b_d = req0_b;
        end else if (gnt1) begin
            unit_a_d = req1_a;
            unit_b_d = req1_b;
        end
    end

    // Result steering: the tag leaving the line names the owner of unit_d
    always_comb begin
        res0_vld_d = ret_vld && (ret_id == ID_REQ0);
        res1_vld_d = ret_vld && (ret_id == ID_REQ1);
        res0_dat_d = res0_vld_d ? unit_d : res0_dat_q;
        res1_dat_d = res1_vld_d ? unit_d : res1_dat_q;
    end

    // State; pointer resets to requester 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= ID_REQ1;
            unit_a_q   <= '0;
            unit_b_q   <= '0;
            res0_vld_q <= 1'b0;
            res1_vld_q <= 1'b0;
            res0_dat_q <= '0;
            res1_dat_q <= '0;
        end else begin
            last_q     <= last_d;
            unit_a_q   <= unit_a_d;
            unit_b_q   <= unit_b_d;
            res0_vld_q <= res0_vld_d;
            res1_vld_q <= res1_vld_d;
            res0_dat_q <= res0_dat_d;
            res1_dat_q <= res1_dat_d;
        end
    end

    flp_tag_delay #(
        .LAT(LAT)
    ) u_tags (
        .clk_i    (clk),
        .rst_ni   (rst),
        .tag_i    (tag_in),
        .vld_o    (ret_vld),
        .id_o     (ret_id),
        .any_vld_o(any_vld)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign unit_a     = unit_a_q;
    assign unit_b     = unit_b_q;
    assign res0_valid = res0_vld_q;
    assign res1_valid = res1_vld_q;
    assign res0_d     = res0_dat_q;
    assign res1_d     = res1_dat_q;
    assign busy       = any_vld;

endmodule

// File: tb/tb_flp_pipe_arbiter.sv
// Bench for flp_pipe_arbiter: three instances (LAT=3,1,7) share one stimulus,
// each fed by a behavioural FLP adder delayed to match its LAT.
module tb_flp_pipe_arbiter;

    typedef struct {
        int          c;
        int          id;
        logic [31:0] d;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tot = 0;
    int   bad = 0;

    logic        r0v, r1v;
    logic [31:0] r0a, r0b, r1a, r1b;

    logic [2:0]       rdy0, rdy1, res0v, res1v, busy;
    logic [2:0][31:0] res0d, res1d, ua, ub, ud;

    ev_t evq [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Positive normal operands only; exact for the values used here
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  e;
        logic [24:0] mx, my, m;
        x = a; y = b;
        if (b[30:23] > a[30:23]) begin x = b; y = a; end
        e  = x[30:23];
        mx = {2'b01, x[22:0]};
        my = {2'b01, y[22:0]} >> (x[30:23] - y[30:23]);
        m  = mx + my;
        if (m[24]) begin m = m >> 1; e = e + 8'd1; end
        return {1'b0, e, m[22:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L  = (g == 0) ? 3 : (g == 1) ? 1 : 7;
        localparam int PD = (L > 1) ? L - 1 : 1;
        logic [31:0] pipe [0:PD-1];

        always @(posedge clk) begin
            pipe[0] <= fadd(ua[g], ub[g]);
            for (int i = 1; i < PD; i++) pipe[i] <= pipe[i-1];
        end
        assign ud[g] = (L == 1) ? fadd(ua[g], ub[g]) : pipe[PD-1];

        flp_pipe_arbiter #(.W(32), .LAT(L)) u_dut (
            .clk       (clk),
            .rst       (rst_n),
            .req0_valid(r0v),
            .req0_ready(rdy0[g]),
            .req0_a    (r0a),
            .req0_b    (r0b),
            .req1_valid(r1v),
            .req1_ready(rdy1[g]),
            .req1_a    (r1a),
            .req1_b    (r1b),
            .res0_valid(res0v[g]),
            .res0_d    (res0d[g]),
            .res1_valid(res1v[g]),
            .res1_d    (res1d[g]),
            .unit_a    (ua[g]),
            .unit_b    (ub[g]),
            .unit_d    (ud[g]),
            .busy      (busy[g])
        );

        always @(negedge clk) begin
            ev_t e;
            if (res0v[g]) begin e.c = cyc; e.id = 0; e.d = res0d[g]; evq[g].push_back(e); end
            if (res1v[g]) begin e.c = cyc; e.id = 1; e.d = res1d[g]; evq[g].push_back(e); end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_logs();
        for (int g = 0; g < 3; g++) evq[g].delete();
    endtask

    // Expect n result pulses on consecutive cycles starting at first
    task automatic chk_res(input string tag, input int g, input int first, input int n,
                           input logic [7:0] ids, input logic [7:0][31:0] d);
        chk({tag, "_cnt"}, evq[g].size(), n);
        for (int i = 0; i < n && i < evq[g].size(); i++) begin
            chk({tag, "_cyc"}, evq[g][i].c, first + i);
            chk({tag, "_id"},  evq[g][i].id, {31'd0, ids[i]});
            chk({tag, "_dat"}, evq[g][i].d, d[i]);
        end
    endtask

    int               p;
    logic [7:0][31:0] ed;
    logic [7:0][31:0] ea;
    logic [7:0][31:0] eb;

    initial begin
        rst_n = 1'b0;
        r0v = 0; r1v = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0;
        ed = '0; ea = '0; eb = '0;
        repeat (2) @(negedge clk);
        chk("rst_ua", ua[0], 0);
        chk("rst_busy", {31'd0, busy[0]}, 0);
        chk("rst_res0v", {31'd0, res0v[0]}, 0);
        chk("rst_res0d", res0d[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single req0 op
        r0v = 1; r0a = 32'h3F800000; r0b = 32'h40000000;
        #1;
        chk("s1_rdy0", {31'd0, rdy0[0]}, 1);
        chk("s1_rdy1", {31'd0, rdy1[0]}, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            r0v = 0;
            chk("s1_res0v", {31'd0, res0v[0]}, {31'd0, k == 4});
            chk("s1_res1v", {31'd0, res1v[0]}, 0);
            if (k == 1) begin
                chk("s1_busy", {31'd0, busy[0]}, 1);
                chk("s1_ua", ua[0], 32'h3F800000);
            end
            if (k == 4) begin
                chk("s1_res0d", res0d[0], 32'h40400000);
                chk("s1_idle", {31'd0, busy[0]}, 0);
            end
        end

        // 3: req1 only, five back-to-back ops (leaves pointer at req1)
        clr_logs();
        ea[0] = 32'h3F800000; eb[0] = 32'h3F800000; ed[0] = 32'h40000000;
        ea[1] = 32'h3F800000; eb[1] = 32'h40000000; ed[1] = 32'h40400000;
        ea[2] = 32'h40000000; eb[2] = 32'h40000000; ed[2] = 32'h40800000;
        ea[3] = 32'h40000000; eb[3] = 32'h40800000; ed[3] = 32'h40C00000;
        ea[4] = 32'h40800000; eb[4] = 32'h40800000; ed[4] = 32'h41000000;
        p = cyc;
        for (int i = 0; i < 5; i++) begin
            r1v = 1; r1a = ea[i]; r1b = eb[i];
            #1 chk("s3_rdy1", {31'd0, rdy1[0]}, 1);
            @(negedge clk);
        end
        r1v = 0;
        repeat (12) @(negedge clk);
        chk_res("s3", 0, p + 4, 5, 8'h1F, ed);

        // 2: contention for four cycles, checked on all three latencies
        clr_logs();
        p = cyc;
        r0v = 1; r0a = 32'h3F800000; r0b = 32'h3F800000;
        r1v = 1; r1a = 32'h40800000; r1b = 32'h40800000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("s2_rdy0", {31'd0, rdy0[0]}, {31'd0, k % 2 == 0});
            chk("s2_rdy1", {31'd0, rdy1[0]}, {31'd0, k % 2 == 1});
            @(negedge clk);
        end
        r0v = 0; r1v = 0;
        repeat (14) @(negedge clk);
        ed = '0;
        ed[0] = 32'h40000000; ed[1] = 32'h41000000;
        ed[2] = 32'h40000000; ed[3] = 32'h41000000;
        chk_res("s2_lat3", 0, p + 4, 4, 8'h0A, ed);
        chk_res("s2_lat1", 1, p + 2, 4, 8'h0A, ed);
        chk_res("s2_lat7", 2, p + 8, 4, 8'h0A, ed);

        // 5: req1 waits one cycle behind req0, operands held
        clr_logs();
        p = cyc;
        r0v = 1; r0a = 32'h3F800000; r0b = 32'h3F800000;
        r1v = 1; r1a = 32'h40000000; r1b = 32'h40400000;
        #1;
        chk("s5_rdy0_a", {31'd0, rdy0[0]}, 1);
        chk("s5_rdy1_a", {31'd0, rdy1[0]}, 0);
        @(negedge clk);
        r0a = 32'h40800000; r0b = 32'h40800000;
        #1;
        chk("s5_rdy1_b", {31'd0, rdy1[0]}, 1);
        chk("s5_rdy0_b", {31'd0, rdy0[0]}, 0);
        @(negedge clk);
        chk("s5_ua", ua[0], 32'h40000000);
        chk("s5_ub", ub[0], 32'h40400000);
        #1 chk("s5_rdy0_c", {31'd0, rdy0[0]}, 1);
        @(negedge clk);
        r0v = 0; r1v = 0;
        repeat (10) @(negedge clk);
        ed = '0;
        ed[0] = 32'h40000000; ed[1] = 32'h40A00000; ed[2] = 32'h41000000;
        chk_res("s5", 0, p + 4, 3, 8'h02, ed);

        // 4: reset with two ops in flight
        r0v = 1; r0a = 32'h3F800000; r0b = 32'h3F800000;
        @(negedge clk);
        r0a = 32'h40000000; r0b = 32'h40000000;
        @(negedge clk);
        r0v = 0;
        rst_n = 1'b0;
        #1;
        chk("s4_ua", ua[0], 0);
        chk("s4_ub", ub[0], 0);
        chk("s4_res0d", res0d[0], 0);
        chk("s4_res1d", res1d[0], 0);
        chk("s4_res0v", {31'd0, res0v[0]}, 0);
        chk("s4_res1v", {31'd0, res1v[0]}, 0);
        chk("s4_busy", {31'd0, busy[0]}, 0);
        #1 clr_logs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("s4_nores_lat3", evq[0].size(), 0);
        chk("s4_nores_lat1", evq[1].size(), 0);
        chk("s4_nores_lat7", evq[2].size(), 0);
        chk("s4_busy_after", {31'd0, busy[0]}, 0);
        r0v = 1; r1v = 1;
        #1;
        chk("s4_first_rdy0", {31'd0, rdy0[0]}, 1);
        chk("s4_first_rdy1", {31'd0, rdy1[0]}, 0);
        @(negedge clk);
        r0v = 0; r1v = 0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
